// File: rtl/pkt_check_rx_if.sv
// Stream channel bundle (data, byte strobes, sideband, framing, handshake)
// shared by the receive and forward sides of the packet checker.
interface pkt_stream_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_check_rx.sv
// Receive-side packet checker: one-deep forwarding slice plus per-packet
// sequence-gap, latency and traffic statistics taken from the first beat.
module pkt_check_rx #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int TIME_STAMP_DWIDTH    = 64,
    parameter int C_PKT_COUNT_DWIDTH   = 64,
    parameter int SEQ_POS              = 128,
    parameter int TS_POS               = 192
) (
    input  logic                          axi_aclk,
    input  logic                          axi_resetn,
    pkt_stream_if.slave                   s_axis,
    pkt_stream_if.master                  m_axis,
    input  logic [TIME_STAMP_DWIDTH-1:0]  time_stamp,
    input  logic                          stat_clear,
    output logic [C_PKT_COUNT_DWIDTH-1:0] rx_pkt_count,
    output logic [C_PKT_COUNT_DWIDTH-1:0] rx_byte_count,
    output logic [C_PKT_COUNT_DWIDTH-1:0] seq_lost_count,
    output logic [C_PKT_COUNT_DWIDTH-1:0] seq_ooo_count,
    output logic [TIME_STAMP_DWIDTH-1:0]  last_latency,
    output logic [TIME_STAMP_DWIDTH-1:0]  max_latency
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int TW = TIME_STAMP_DWIDTH;
    localparam int CW = C_PKT_COUNT_DWIDTH;

    if (C_M_AXIS_DATA_WIDTH != DW || C_M_AXIS_TUSER_WIDTH != UW) begin : g_width_chk
        $error("pkt_check_rx: master and slave stream widths must match");
    end

    typedef enum logic [0:0] {ST_SOP, ST_BODY} state_e;

    state_e          state_q, state_d;
    logic            m_vld_q, m_last_q;
    logic [DW-1:0]   m_data_q;
    logic [SW-1:0]   m_strb_q;
    logic [UW-1:0]   m_user_q;
    logic            s_rdy, acc, sop, first_q;
    logic [63:0]     seq, exp_q, dlt;
    logic [TW-1:0]   tx_ts, lat, last_lat_q, max_lat_q;
    logic [CW:0]     strb_cnt;
    logic [CW-1:0]   pkt_q, byte_q, lost_q, ooo_q;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW:0] b);
        logic [CW+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s[CW+1:CW] != 2'b00) ? '1 : s[CW-1:0];
    endfunction

    // Ready is gated by reset so no beat is taken while the slice is held clear.
    assign s_rdy         = axi_resetn & (~m_vld_q | m_axis.tready);
    assign s_axis.tready = s_rdy;
    assign acc           = s_axis.tvalid & s_rdy;
    assign sop           = (state_q == ST_SOP);
    assign seq           = s_axis.tdata[SEQ_POS +: 64];
    assign tx_ts         = s_axis.tdata[TS_POS +: TW];
    assign lat           = time_stamp - tx_ts;
    assign dlt           = seq - exp_q;

    assign m_axis.tvalid = m_vld_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tstrb  = m_strb_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = m_last_q;

    assign rx_pkt_count   = pkt_q;
    assign rx_byte_count  = byte_q;
    assign seq_lost_count = lost_q;
    assign seq_ooo_count  = ooo_q;
    assign last_latency   = last_lat_q;
    assign max_latency    = max_lat_q;

    always_comb begin
        strb_cnt = '0;
        for (int i = 0; i < SW; i++) strb_cnt = strb_cnt + {{CW{1'b0}}, s_axis.tstrb[i]};
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_strb_q <= '0;
            m_user_q <= '0;
            m_last_q <= 1'b0;
        end else if (s_rdy) begin
            // Slot is empty or retiring this edge, so it simply follows the input.
            m_vld_q <= s_axis.tvalid;
            if (s_axis.tvalid) begin
                m_data_q <= s_axis.tdata;
                m_strb_q <= s_axis.tstrb;
                m_user_q <= s_axis.tuser;
                m_last_q <= s_axis.tlast;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state_q <= ST_SOP;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            if (sop && !s_axis.tlast)  state_d = ST_BODY;
            else if (!sop && s_axis.tlast) state_d = ST_SOP;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_q      <= '0;
            byte_q     <= '0;
            lost_q     <= '0;
            ooo_q      <= '0;
            last_lat_q <= '0;
            max_lat_q  <= '0;
            exp_q      <= '0;
            first_q    <= 1'b1;
        end else if (stat_clear) begin
            pkt_q      <= '0;
            byte_q     <= '0;
            lost_q     <= '0;
            ooo_q      <= '0;
            last_lat_q <= '0;
            max_lat_q  <= '0;
            first_q    <= 1'b1;
        end else if (acc) begin
            byte_q <= sat_add(byte_q, strb_cnt);
            if (s_axis.tlast) pkt_q <= sat_add(pkt_q, (CW+1)'(1));
            if (sop) begin
                last_lat_q <= lat;
                if (lat > max_lat_q) max_lat_q <= lat;
                // Forward gaps count as lost; a backward step counts once and keeps the window.
                if (first_q) begin
                    exp_q   <= seq + 64'd1;
                    first_q <= 1'b0;
                end else if (dlt == 64'd0) begin
                    exp_q <= seq + 64'd1;
                end else if (!dlt[63]) begin
                    lost_q <= sat_add(lost_q, (CW+1)'(dlt));
                    exp_q  <= seq + 64'd1;
                end else begin
                    ooo_q <= sat_add(ooo_q, (CW+1)'(1));
                end
            end
        end
    end
endmodule
